// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Holds fetched words with their PCs and presents the oldest entry to decode
// together with pre-sliced RV32 fields. A flush clears the queue in one cycle.
module instruction_prefetch_queue #(
  parameter int                   DEPTH    = 4,
  parameter int                   INSTR_W  = 32,
  parameter int                   PC_W     = 32,
  parameter logic [INSTR_W-1:0]   NOP_WORD = 32'h0000_0013
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [6:0]                 opcode,
  output logic [4:0]                 rd,
  output logic [2:0]                 funct3,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [6:0]                 funct7,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic               wr_en;
  logic               rd_en;

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush wins over both sides of the handshake.
  assign wr_en = in_valid && in_ready && !flush;
  assign rd_en = out_valid && out_ready && !flush;

  // Storage is only written on accepted words; flush leaves it untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (wr_en) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks writes minus reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry is masked when empty, since flushed storage may hold stale words.
  always_comb begin
    out_instr = NOP_WORD;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = instr_mem[rd_ptr];
      out_pc    = pc_mem[rd_ptr];
    end
  end

  assign opcode = out_instr[6:0];
  assign rd     = out_instr[11:7];
  assign funct3 = out_instr[14:12];
  assign rs1    = out_instr[19:15];
  assign rs2    = out_instr[24:20];
  assign funct7 = out_instr[31:25];

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference.
module tb_instruction_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  instruction_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of accepted words.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_rd;
      bit do_wr;
      do_rd = (mq.size() != 0) && out_ready;
      do_wr = in_valid && (mq.size() != DEPTH);
      if (do_rd) void'(mq.pop_front());
      if (do_wr) mq.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  // Every cycle, after state settles, compare all outputs with the reference.
  always @(posedge clock) begin
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    #2;
    e_instr = (mq.size() != 0) ? mq[0].instr : NOP;
    e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
    chk("m_count",     64'(count),     64'(mq.size()));
    chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("m_in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
    chk("m_out_instr", 64'(out_instr), 64'(e_instr));
    chk("m_out_pc",    64'(out_pc),    64'(e_pc));
    chk("m_fields",    64'({funct7, rs2, rs1, funct3, rd, opcode}), 64'(e_instr));
  end

  task automatic write_word(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    #12 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'h13);
    chk("rst_opcode",    64'(opcode),    64'h13);

    // Single word then one read.
    write_word(32'h00A2_8293, 32'h0);
    chk("one_valid",  64'(out_valid), 64'd1);
    chk("one_count",  64'(count),     64'd1);
    chk("one_rd",     64'(rd),        64'd5);
    chk("one_rs1",    64'(rs1),       64'd5);
    chk("one_funct3", 64'(funct3),    64'd0);
    chk("one_opcode", 64'(opcode),    64'h13);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("one_drain_count", 64'(count),     64'd0);
    chk("one_drain_valid", 64'(out_valid), 64'd0);

    // Fill to full, hold a fifth word, then drain across the pointer wrap.
    for (int i = 0; i < 4; i++) write_word(32'h1000_0013 + 32'(i), 32'(4 * i));
    chk("full_count",    64'(count),    64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = 32'h1000_0017; in_pc = 32'd16;
    repeat (3) @(negedge clock);
    chk("full_hold_count", 64'(count),  64'd4);
    chk("full_hold_head",  64'(out_pc), 64'd0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("full_after_read", 64'(count), 64'd3);
    @(negedge clock);
    in_valid = 1'b0;
    chk("full_refill", 64'(count), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      chk("wrap_order_pc", 64'(out_pc), 64'(4 * k));
      out_ready = 1'b1;
      @(negedge clock);
    end
    out_ready = 1'b0;
    chk("wrap_empty", 64'(count), 64'd0);

    // Simultaneous read and write at count=2.
    write_word(32'h2000_0013, 32'h100);
    write_word(32'h2000_0093, 32'h104);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = 32'h2000_0113 + 32'(k << 7); in_pc = 32'h108 + 32'(4 * k);
      @(negedge clock);
      chk("rw_count", 64'(count),  64'd2);
      chk("rw_head",  64'(out_pc), 64'(32'h104 + 32'(4 * k)));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin out_ready = 1'b1; @(negedge clock); end
    out_ready = 1'b0;

    // Flush at count=3 with both handshakes active.
    for (int i = 0; i < 3; i++) write_word(32'h3000_0013, 32'h200 + 32'(4 * i));
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h3FFF_FF93; in_pc = 32'h2FC;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count",  64'(count),     64'd0);
    chk("flush_valid",  64'(out_valid), 64'd0);
    chk("flush_pc",     64'(out_pc),    64'd0);
    chk("flush_instr",  64'(out_instr), 64'h13);
    @(negedge clock);
    chk("flush_no_leak", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges at count=2.
    write_word(32'h4000_0013, 32'h300);
    write_word(32'h4000_0093, 32'h304);
    #2 reset = 1'b1;
    #1;
    chk("areset_count", 64'(count),     64'd0);
    chk("areset_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Randomized traffic; a stalled word is held stable until accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_instr = $urandom;
        in_pc    = in_pc + 32'd4;
      end
      out_ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      flush     = ($urandom_range(0, 31) == 0);
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
